md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: maximum BUSY cycles before an operation is aborted.
REQ-002 SHALL have parameter RSTATUS, default 30: register index written on an exception.
REQ-003 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port issue_valid, input, 1 bit: the decode stage presents a decoded R-type instruction.
REQ-006 SHALL have port aluop, input, 5 bits: decoded ALU op; MUL=00110, DIV=00111.
REQ-007 SHALL have port rd, input, 5 bits: destination register.
REQ-008 SHALL have ports op_a and op_b, input, 32 bits each: source operand values.
REQ-009 SHALL have port flush, input, 1 bit: kill any in-flight operation.
REQ-010 SHALL have port md_start, output, 1 bit: one-cycle start pulse to the mult/div unit.
REQ-011 SHALL have port md_is_div, output, 1 bit: 1 selects divide, 0 selects multiply.
REQ-012 SHALL have ports md_a and md_b, output, 32 bits each: latched operands.
REQ-013 SHALL have port md_ready, input, 1 bit: unit result valid.
REQ-014 SHALL have port md_exc, input, 1 bit: unit overflow flag, valid with md_ready.
REQ-015 SHALL have port md_result, input, 32 bits: unit result.
REQ-016 SHALL have port stall, output, 1 bit: freezes fetch and decode.
REQ-017 SHALL have port wb_valid, output, 1 bit: writeback strobe.
REQ-018 SHALL have port wb_rd, output, 5 bits: writeback register index.
REQ-019 SHALL have port wb_data, output, 32 bits: writeback value.

Function
REQ-020 SHALL implement four states with these transitions:
- IDLE -> START: on accept.
- IDLE -> WB: on accept of a divide by zero.
- START -> BUSY: unconditionally.
- BUSY -> WB: on md_ready or on timeout.
- WB -> IDLE: unconditionally.
REQ-021 SHALL accept an operation only in IDLE, when issue_valid=1 and aluop is MUL or DIV; otherwise it SHALL stay in IDLE.
REQ-022 SHALL, on accept, register rd, is_div, op_a and op_b, and SHALL hold md_a, md_b and md_is_div stable until the next accept.
REQ-023 SHALL assert md_start only in START, for exactly one cycle.
REQ-024 SHALL ignore md_ready outside BUSY.
REQ-025 SHALL clear a 6-bit BUSY cycle counter on entry to BUSY and increment it each BUSY cycle; count == TIMEOUT-1 without md_ready SHALL mean timeout.
REQ-026 SHALL let md_ready win when md_ready and timeout occur in the same cycle.
REQ-027 SHALL, for DIV with op_b == 0 at accept, go directly to WB with a divide exception and never assert md_start.
REQ-028 SHALL, in WB with no exception, drive wb_valid=1, wb_rd=latched rd and wb_data=md_result captured at md_ready.
REQ-029 SHALL, in WB with an exception (md_exc, timeout or divide by zero), drive wb_valid=1, wb_rd=RSTATUS and wb_data=4 for MUL or 5 for DIV.
REQ-030 SHALL suppress wb_valid when latched rd == 0 and there is no exception.
REQ-031 SHALL drive stall combinationally high in the accept cycle and throughout START and BUSY, and low in WB and in IDLE without accept.
REQ-032 SHALL, when flush=1 in START, BUSY or WB, go to IDLE next cycle with no wb_valid and no further md_start; flush SHALL also block acceptance in IDLE.
REQ-033 SHALL keep wb_valid at 1 for exactly one cycle per completed operation.
REQ-034 SHALL give a latency of accept cycle N, md_start at N+1, earliest WB at N+3.

Reset
REQ-035 SHALL, on reset_n=0, immediately and asynchronously set state=IDLE, counter=0, and latched rd, operands and result to 0.
REQ-036 SHALL hold all outputs at 0 during reset, including an abort of an operation in progress with no writeback.
REQ-037 SHALL restart from a clean IDLE after reset is released.

Structure
REQ-038 SHALL take the MUL/DIV aluop codes, the R-type opcode 00000, the state enum and the exception codes 4 and 5 from the shared processor package.
REQ-039 SHALL place the BUSY counter and timeout compare in one sub-module, md_watchdog (inputs clear and enable, output expired).

Verification
REQ-040 SHALL cover MUL 7*6, rd=3, md_ready after 5 BUSY cycles -> one md_start; WB with wb_rd=3, wb_data=42; stall low in WB.
REQ-041 SHALL cover DIV with op_b=0, rd=4 -> no md_start; WB at N+1 with wb_rd=30, wb_data=5.
REQ-042 SHALL cover MUL with md_ready held low -> WB after 40 BUSY cycles with wb_rd=30, wb_data=4.
REQ-043 SHALL cover flush asserted in BUSY cycle 2 -> IDLE next cycle, wb_valid stays 0, and a late md_ready is ignored.
REQ-044 SHALL cover reset_n low mid-BUSY -> outputs 0 immediately; after release, a new MUL 3*3 completes with wb_data=9.
REQ-045 SHALL cover MUL with rd=0 and no exception -> no wb_valid, and stall released on schedule.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared processor constants for the multiply/divide sequencer:
// ALU op encodings, the R-type opcode, sequencer states and exception codes.
package md_sequencer_pkg;

   localparam logic [4:0]  ALUOP_MUL    = 5'b00110;
   localparam logic [4:0]  ALUOP_DIV    = 5'b00111;
   localparam logic [4:0]  OPCODE_RTYPE = 5'b00000;

   localparam logic [31:0] EXC_MUL = 32'd4;
   localparam logic [31:0] EXC_DIV = 32'd5;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_START,
      MD_BUSY,
      MD_WB
   } md_state_e;

   function automatic logic is_md_op(input logic [4:0] op);
      return (op == ALUOP_MUL) || (op == ALUOP_DIV);
   endfunction

endpackage

// File: rtl/md_sequencer_watchdog.sv
// BUSY-cycle watchdog: counts cycles while enabled and flags the last
// permitted cycle so the sequencer can abort a hung unit.
module md_watchdog #(
   parameter int unsigned TIMEOUT = 40
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [5:0] LIMIT = 6'(TIMEOUT - 1);

   logic [5:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 6'd1;
      end
   end

   assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/md_sequencer.sv
// Issue/writeback sequencer between decode and the multi-cycle mult/div unit:
// latches operands, starts the unit, waits with a watchdog and writes back.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT = 40,
   parameter int unsigned RSTATUS = 30
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        issue_valid,
   input  logic [4:0]  aluop,
   input  logic [4:0]  rd,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        md_start,
   output logic        md_is_div,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_ready,
   input  logic        md_exc,
   input  logic [31:0] md_result,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam logic [4:0] RSTATUS_IDX = 5'(RSTATUS);

   md_state_e   state;
   md_state_e   next_state;

   logic        accept;
   logic        is_div_in;
   logic        div_by_zero;
   logic        expired;

   logic [4:0]  rd_q;
   logic        is_div_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] result_q;
   logic        exc_q;

   // Accept is gated by reset_n so stall stays low while reset is held.
   assign accept      = reset_n && (state == MD_IDLE) && issue_valid && !flush
                        && is_md_op(aluop);
   assign is_div_in   = (aluop == ALUOP_DIV);
   assign div_by_zero = is_div_in && (op_b == '0);

   md_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (state == MD_START),
      .enable  (state == MD_BUSY),
      .expired (expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= MD_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         MD_IDLE: begin
            if (accept) begin
               next_state = div_by_zero ? MD_WB : MD_START;
            end
         end
         MD_START: begin
            next_state = flush ? MD_IDLE : MD_BUSY;
         end
         MD_BUSY: begin
            if (flush) begin
               next_state = MD_IDLE;
            end else if (md_ready || expired) begin
               next_state = MD_WB;
            end
         end
         MD_WB: begin
            next_state = MD_IDLE;
         end
         default: begin
            next_state = MD_IDLE;
         end
      endcase
   end

   // md_ready takes priority over a simultaneous watchdog expiry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_q     <= '0;
         is_div_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         if (accept) begin
            rd_q     <= rd;
            is_div_q <= is_div_in;
            a_q      <= op_a;
            b_q      <= op_b;
            exc_q    <= div_by_zero;
         end
         if (state == MD_BUSY) begin
            if (md_ready) begin
               result_q <= md_result;
               exc_q    <= md_exc;
            end else if (expired) begin
               exc_q    <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      md_start = (state == MD_START) && !flush;
      stall    = accept || (state == MD_START) || (state == MD_BUSY);
      wb_valid = 1'b0;
      wb_rd    = '0;
      wb_data  = '0;
      if ((state == MD_WB) && !flush) begin
         if (exc_q) begin
            wb_valid = 1'b1;
            wb_rd    = RSTATUS_IDX;
            wb_data  = is_div_q ? EXC_DIV : EXC_MUL;
         end else if (rd_q != '0) begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = result_q;
         end
      end
   end

   assign md_is_div = is_div_q;
   assign md_a      = a_q;
   assign md_b      = b_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: stimulus pushes expected writebacks into a
// queue, a negedge monitor pops and compares whenever wb_valid is seen.
module tb_md_sequencer;

   localparam logic [4:0] MUL = 5'b00110;
   localparam logic [4:0] DIV = 5'b00111;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic [4:0]  aluop = '0;
   logic [4:0]  rd = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        flush = 1'b0;
   logic        md_ready = 1'b0;
   logic        md_exc = 1'b0;
   logic [31:0] md_result = '0;
   logic        md_start;
   logic        md_is_div;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int  checks = 0;
   int  errs = 0;
   int  start_cnt = 0;
   wb_t exp_q[$];
   wb_t mon_e;

   md_sequencer #(
      .TIMEOUT (40),
      .RSTATUS (30)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .issue_valid (issue_valid),
      .aluop       (aluop),
      .rd          (rd),
      .op_a        (op_a),
      .op_b        (op_b),
      .flush       (flush),
      .md_start    (md_start),
      .md_is_div   (md_is_div),
      .md_a        (md_a),
      .md_b        (md_b),
      .md_ready    (md_ready),
      .md_exc      (md_exc),
      .md_result   (md_result),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (md_start) start_cnt++;
      if (wb_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL wb_unexpected: got rd=%0d data=%0d, expected no writeback", wb_rd, wb_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
            check("wb_data", wb_data, mon_e.data);
         end
      end
   end

   // Issue one op, answer from the unit in BUSY cycle rdy_at (0 = never).
   task automatic run_op(input logic [4:0] op, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b,
                         input int rdy_at, input logic [31:0] res,
                         input logic exc, input logic wb_exp);
      int s0;
      s0 = start_cnt;
      tick();
      issue_valid = 1'b1; aluop = op; rd = r; op_a = a; op_b = b;
      #1 check("accept_stall", 32'(stall), 1);
      tick();
      issue_valid = 1'b0; aluop = '0; rd = '0; op_a = '1; op_b = '1;
      #1;
      check("start_pulse", 32'(md_start), 1);
      check("md_a", md_a, a);
      check("md_b", md_b, b);
      check("md_is_div", 32'(md_is_div), 32'(op == DIV));
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == rdy_at) begin
            md_ready = 1'b1; md_result = res; md_exc = exc;
         end
         #1;
         check("busy_stall", 32'(stall), 1);
         check("busy_no_wb", 32'(wb_valid), 0);
         if (k == rdy_at) break;
      end
      tick();
      md_ready = 1'b0; md_exc = 1'b0; md_result = 32'hDEAD_BEEF;
      #1;
      check("wb_stall_low", 32'(stall), 0);
      check("wb_strobe", 32'(wb_valid), 32'(wb_exp));
      tick();
      #1;
      check("wb_one_cycle", 32'(wb_valid), 0);
      check("one_start", 32'(start_cnt - s0), 1);
   endtask

   initial begin
      int s0;
      issue_valid = 1'b1; aluop = MUL; rd = 5'd3;
      #2;
      check("rst_stall", 32'(stall), 0);
      check("rst_start", 32'(md_start), 0);
      check("rst_wb_valid", 32'(wb_valid), 0);
      check("rst_md_a", md_a, 0);
      issue_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // MUL 7*6 -> r3 = 42, unit answers in BUSY cycle 5
      exp_q.push_back('{rd: 5'd3, data: 32'd42});
      run_op(MUL, 5'd3, 32'd7, 32'd6, 5, 32'd42, 1'b0, 1'b1);

      // DIV by zero -> straight to WB with status 5 into r30, no start
      exp_q.push_back('{rd: 5'd30, data: 32'd5});
      s0 = start_cnt;
      tick();
      issue_valid = 1'b1; aluop = DIV; rd = 5'd4; op_a = 32'd9; op_b = 32'd0;
      #1 check("dbz_accept_stall", 32'(stall), 1);
      tick();
      issue_valid = 1'b0;
      #1;
      check("dbz_wb", 32'(wb_valid), 1);
      check("dbz_stall", 32'(stall), 0);
      check("dbz_no_start", 32'(md_start), 0);
      tick();
      #1 check("dbz_idle", 32'(wb_valid), 0);
      check("dbz_start_cnt", 32'(start_cnt - s0), 0);

      // Unit never answers -> timeout after 40 BUSY cycles, status 4
      exp_q.push_back('{rd: 5'd30, data: 32'd4});
      run_op(MUL, 5'd11, 32'd2, 32'd3, 0, 32'd0, 1'b0, 1'b1);

      // md_ready on the final BUSY cycle beats the timeout
      exp_q.push_back('{rd: 5'd10, data: 32'd123});
      run_op(MUL, 5'd10, 32'd41, 32'd3, 40, 32'd123, 1'b0, 1'b1);

      // Normal DIV 100/7 -> r8 = 14
      exp_q.push_back('{rd: 5'd8, data: 32'd14});
      run_op(DIV, 5'd8, 32'd100, 32'd7, 3, 32'd14, 1'b0, 1'b1);

      // Unit overflow on a DIV -> status 5
      exp_q.push_back('{rd: 5'd30, data: 32'd5});
      run_op(DIV, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0, 1'b1, 1'b1);

      // rd = 0 -> no writeback
      run_op(MUL, 5'd0, 32'd11, 32'd7, 2, 32'd77, 1'b0, 1'b0);

      // Flush in BUSY cycle 2, then a late md_ready must be ignored
      s0 = start_cnt;
      tick();
      issue_valid = 1'b1; aluop = MUL; rd = 5'd6; op_a = 32'd2; op_b = 32'd2;
      tick();
      issue_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("flush_idle_stall", 32'(stall), 0);
      check("flush_no_wb", 32'(wb_valid), 0);
      md_ready = 1'b1; md_result = 32'd99;
      tick();
      #1 check("late_ready_no_wb", 32'(wb_valid), 0);
      tick();
      md_ready = 1'b0;
      check("flush_one_start", 32'(start_cnt - s0), 1);

      // Reset mid-BUSY aborts silently; clean restart with 3*3
      tick();
      issue_valid = 1'b1; aluop = MUL; rd = 5'd7; op_a = 32'd5; op_b = 32'd5;
      tick();
      issue_valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check("mid_rst_stall", 32'(stall), 0);
      check("mid_rst_start", 32'(md_start), 0);
      check("mid_rst_wb", 32'(wb_valid), 0);
      check("mid_rst_wb_rd", 32'(wb_rd), 0);
      check("mid_rst_wb_data", wb_data, 0);
      check("mid_rst_md_a", md_a, 0);
      check("mid_rst_md_b", md_b, 0);
      tick();
      reset_n = 1'b1;
      exp_q.push_back('{rd: 5'd5, data: 32'd9});
      run_op(MUL, 5'd5, 32'd3, 32'd3, 1, 32'd9, 1'b0, 1'b1);

      tick();
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded its time bound");
      $fatal(1, "timeout");
   end

endmodule
